// File: rtl/tri_job_sched.sv
// Two-client scheduler for the triangle rasterizer: arbitrates whole triangles,
// streams the three vertices to the engine and posts one completion record per job.
module tri_job_sched #(
    parameter int WAIT_MAX   = 8,
    parameter int CNT_W      = 7,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [17:0]      tri_0,
    input  logic [17:0]      tri_1,
    output logic             ack0,
    output logic             ack1,
    output logic             eng_nt,
    output logic [2:0]       eng_xi,
    output logic [2:0]       eng_yi,
    input  logic             eng_busy,
    input  logic             eng_po,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] done_cnt,
    output logic             done_err,
    output logic             sched_busy
);
    localparam int                WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND0     = 3'd1,
        ST_SEND1     = 3'd2,
        ST_SEND2     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_RUN       = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              grant_s;
    logic              win_id_s;
    logic              timeout_s;
    logic [17:0]       sel_tri_s;
    logic              last_grant_r;
    logic              id_r;
    logic [11:0]       verts_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  pt_cnt_r;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, arbitration and timeout decode.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        win_id_s     = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_s      = 1'b1;
                    next_state_s = ST_SEND0;
                    if (req0 && req1) begin
                        win_id_s = FIXED_PRIO ? 1'b0 : ~last_grant_r;
                    end else begin
                        win_id_s = req1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND0: next_state_s = ST_SEND1;
            ST_SEND1: next_state_s = ST_SEND2;
            ST_SEND2: next_state_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                // Busy may still rise in the WAIT_MAX-th wait cycle; give up after that.
                if (eng_busy) begin
                    next_state_s = ST_RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = ST_DONE;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_WAIT_BUSY;
                end
            end
            ST_RUN: begin
                if (!eng_busy) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
        sel_tri_s = win_id_s ? tri_1 : tri_0;
    end

    // Winner bookkeeping and capture of the two trailing vertices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            verts_r      <= 12'd0;
        end else if (grant_s) begin
            last_grant_r <= win_id_s;
            id_r         <= win_id_s;
            verts_r      <= sel_tri_s[11:0];
        end else begin
            last_grant_r <= last_grant_r;
            id_r         <= id_r;
            verts_r      <= verts_r;
        end
    end

    // Busy-rise wait counter and saturating point counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
            pt_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (state_r == ST_WAIT_BUSY) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
            if (state_r == ST_WAIT_BUSY) begin
                pt_cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ST_RUN) && eng_busy && eng_po && (pt_cnt_r != CNT_SAT)) begin
                pt_cnt_r <= pt_cnt_r + CNT_W'(1);
            end else begin
                pt_cnt_r <= pt_cnt_r;
            end
        end
    end

    // Registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            eng_nt     <= 1'b0;
            eng_xi     <= 3'd0;
            eng_yi     <= 3'd0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            done_cnt   <= {CNT_W{1'b0}};
            done_err   <= 1'b0;
            sched_busy <= 1'b0;
        end else begin
            ack0       <= grant_s && !win_id_s;
            ack1       <= grant_s && win_id_s;
            done       <= (next_state_s == ST_DONE);
            sched_busy <= (next_state_s != ST_IDLE);
            case (next_state_s)
                ST_SEND0: begin
                    eng_nt <= 1'b1;
                    eng_xi <= sel_tri_s[17:15];
                    eng_yi <= sel_tri_s[14:12];
                end
                ST_SEND1: begin
                    eng_nt <= 1'b0;
                    eng_xi <= verts_r[11:9];
                    eng_yi <= verts_r[8:6];
                end
                ST_SEND2: begin
                    eng_nt <= 1'b0;
                    eng_xi <= verts_r[5:3];
                    eng_yi <= verts_r[2:0];
                end
                default: begin
                    eng_nt <= 1'b0;
                    eng_xi <= 3'd0;
                    eng_yi <= 3'd0;
                end
            endcase
            if (next_state_s == ST_DONE) begin
                done_id  <= id_r;
                done_err <= timeout_s;
                done_cnt <= timeout_s ? {CNT_W{1'b0}} : pt_cnt_r;
            end else begin
                done_id  <= done_id;
                done_err <= done_err;
                done_cnt <= done_cnt;
            end
        end
    end

endmodule
